// File: rtl/rect_draw_scheduler.sv
// Two-requester rectangle command scheduler: round-robin intake into a small FIFO,
// then one draw at a time handed to the renderer through an IDLE/LOAD/DRAW/RELEASE FSM.
module rect_draw_scheduler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                req0_valid,
  output logic                                req0_ready,
  input  logic [40:0]                         req0_cmd,
  input  logic                                req1_valid,
  output logic                                req1_ready,
  input  logic [40:0]                         req1_cmd,
  output logic                                rr_enable,
  output logic [40:0]                         rr_cmd,
  input  logic                                rr_done,
  output logic                                cmp_valid,
  output logic                                cmp_src,
  output logic                                busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     level
);

  localparam int CMD_W = 41;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(FIFO_DEPTH);
  localparam logic [3:0]       GUARD_LAST = 4'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, RELEASE} state_t;

  state_t             state;
  logic [CMD_W:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               last_grant;
  logic               held_tag;
  logic [3:0]         guard_cnt;

  logic               grant;
  logic               not_full;
  logic               acc0;
  logic               acc1;
  logic               accept;
  logic [CMD_W-1:0]   acc_cmd;
  logic               has_area;
  logic               push;
  logic               pop;

  // When both requesters contend, the one not served last wins.
  always_comb begin
    grant = ~last_grant;
    if (req0_valid && !req1_valid)
      grant = 1'b0;
    else if (req1_valid && !req0_valid)
      grant = 1'b1;
  end

  assign not_full   = (level < FULL_LVL);
  assign req0_ready = resetn && not_full && !grant;
  assign req1_ready = resetn && not_full && grant;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign accept     = acc0 || acc1;
  assign acc_cmd    = acc1 ? req1_cmd : req0_cmd;
  // Zero-width or zero-height rectangles are handshaken and dropped.
  assign has_area   = (|acc_cmd[23:15]) && (|acc_cmd[14:7]);
  assign push       = accept && has_area;
  assign pop        = (state == IDLE) && (level != '0);
  assign busy       = (level != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {acc1, acc_cmd};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      last_grant <= 1'b1;
      guard_cnt  <= '0;
      held_tag   <= 1'b0;
      rr_enable  <= 1'b0;
      rr_cmd     <= '0;
      cmp_valid  <= 1'b0;
      cmp_src    <= 1'b0;
    end else begin
      if (accept)
        last_grant <= acc1;
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        level <= level + LVL_W'(1);
      else if (pop && !push)
        level <= level - LVL_W'(1);

      cmp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            {held_tag, rr_cmd} <= mem[rd_ptr];
            state              <= LOAD;
          end
        end
        LOAD: begin
          rr_enable <= 1'b1;
          guard_cnt <= '0;
          state     <= DRAW;
        end
        DRAW: begin
          // rr_done may still be stale from the previous draw until the guard expires.
          if (guard_cnt < GUARD_LAST) begin
            guard_cnt <= guard_cnt + 4'd1;
          end else if (rr_done) begin
            rr_enable <= 1'b0;
            cmp_valid <= 1'b1;
            cmp_src   <= held_tag;
            state     <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// Directed bench for rect_draw_scheduler: reset, single draw, zero size, early done,
// push/pop overlap, reset mid-draw and two-requester contention.
module tb_rect_draw_scheduler;

  logic        clk;
  logic        resetn;
  logic        req0_valid;
  logic        req0_ready;
  logic [40:0] req0_cmd;
  logic        req1_valid;
  logic        req1_ready;
  logic [40:0] req1_cmd;
  logic        rr_enable;
  logic [40:0] rr_cmd;
  logic        rr_done;
  logic        cmp_valid;
  logic        cmp_src;
  logic        busy;
  logic [2:0]  level;

  int passed = 0;
  int total  = 0;
  int cmp_cnt = 0;
  int en_rises = 0;
  logic en_prev = 1'b0;
  logic src_q[$];

  rect_draw_scheduler #(.FIFO_DEPTH(4), .GUARD_CYCLES(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_cmd   (req0_cmd),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_cmd   (req1_cmd),
    .rr_enable  (rr_enable),
    .rr_cmd     (rr_cmd),
    .rr_done    (rr_done),
    .cmp_valid  (cmp_valid),
    .cmp_src    (cmp_src),
    .busy       (busy),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmp_valid) begin
      cmp_cnt++;
      src_q.push_back(cmp_src);
    end
    if (rr_enable && !en_prev)
      en_rises++;
    en_prev = rr_enable;
  end

  function automatic logic [40:0] mk(input int x, input int y, input int w, input int h);
    return {9'(x), 8'(y), 9'(w), 8'(h), 3'd5, 1'b1, 3'd2};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && busy; i++)
      tick();
    chk("drain_idle", busy, 0);
  endtask

  logic [40:0] cmd_a, cmd_b, cmd_c;
  int c0, e0;

  initial begin
    resetn = 1'b0; rr_done = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_cmd = '0; req1_cmd = '0;

    // Reset state; ready held low while in reset
    tick(); tick();
    req0_valid = 1'b1;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_rr_enable", rr_enable, 0);
    chk("rst_rr_cmd", rr_cmd, 0);
    chk("rst_cmp_valid", cmp_valid, 0);
    chk("rst_cmp_src", cmp_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    req0_valid = 1'b0;
    resetn = 1'b1;
    tick();

    // Single command, FSM idle
    cmd_a = mk(10, 20, 5, 4);
    req0_cmd = cmd_a; req0_valid = 1'b1;
    #1;
    chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    tick();                                   // E0
    req0_valid = 1'b0;
    chk("single_lvl_e0", level, 1);
    chk("single_busy_e0", busy, 1);
    chk("single_en_e0", rr_enable, 0);
    tick();                                   // E1
    chk("single_en_e1", rr_enable, 0);
    chk("single_cmd_e1", rr_cmd, cmd_a);
    chk("single_lvl_e1", level, 0);
    tick();                                   // E2
    chk("single_en_e2", rr_enable, 1);
    c0 = cmp_cnt;
    repeat (19) tick();
    chk("single_en_hold", rr_enable, 1);
    chk("single_no_cmp_yet", cmp_cnt, c0);
    rr_done = 1'b1;
    tick();
    rr_done = 1'b0;
    chk("single_cmp_valid", cmp_valid, 1);
    chk("single_cmp_src", cmp_src, 0);
    chk("single_en_release", rr_enable, 0);
    tick();
    chk("single_cmp_pulse", cmp_valid, 0);
    chk("single_cmp_cnt", cmp_cnt, c0 + 1);
    chk("single_lvl_end", level, 0);
    chk("single_busy_end", busy, 0);
    chk("single_cmd_kept", rr_cmd, cmd_a);

    // Zero width from requester 1
    c0 = cmp_cnt; e0 = en_rises;
    req1_cmd = mk(3, 3, 0, 7); req1_valid = 1'b1;
    #1;
    chk("zero_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("zero_lvl", level, 0);
    chk("zero_busy", busy, 0);
    repeat (4) tick();
    chk("zero_no_enable", en_rises, e0);
    chk("zero_no_cmp", cmp_cnt, c0);
    chk("zero_cmd_kept", rr_cmd, cmd_a);

    // Early done held from DRAW entry: two DRAW cycles only
    cmd_b = mk(100, 50, 8, 8);
    req0_cmd = cmd_b; req0_valid = 1'b1; rr_done = 1'b1;
    tick();                                   // E0
    req0_valid = 1'b0;
    tick();                                   // E1 LOAD
    chk("early_en_load", rr_enable, 0);
    tick();                                   // E2 DRAW
    chk("early_en_d1", rr_enable, 1);
    tick();                                   // E3 DRAW
    chk("early_en_d2", rr_enable, 1);
    chk("early_no_cmp_d2", cmp_valid, 0);
    tick();                                   // E4 RELEASE
    chk("early_en_rel", rr_enable, 0);
    chk("early_cmp_valid", cmp_valid, 1);
    rr_done = 1'b0;
    tick();
    chk("early_busy_end", busy, 0);

    // Push and pop on the same edge keep level unchanged
    cmd_b = mk(7, 9, 2, 3);
    cmd_c = mk(11, 13, 4, 6);
    req0_cmd = cmd_b; req0_valid = 1'b1;
    tick();                                   // E0
    chk("pp_lvl_e0", level, 1);
    req0_cmd = cmd_c;
    #1;
    chk("pp_ready_idle", req0_ready, 1);
    tick();                                   // E1 push + pop
    req0_valid = 1'b0;
    chk("pp_lvl_e1", level, 1);
    chk("pp_cmd_first", rr_cmd, cmd_b);
    c0 = cmp_cnt;
    src_q.delete();
    rr_done = 1'b1;
    drain();
    rr_done = 1'b0;
    chk("pp_cmp_cnt", cmp_cnt, c0 + 2);
    chk("pp_cmd_last", rr_cmd, cmd_c);
    chk("pp_src_q_len", src_q.size(), 2);

    // Reset mid-draw with three queued commands
    resetn = 1'b0; tick(); resetn = 1'b1;
    req0_cmd = mk(1, 2, 3, 4); req0_valid = 1'b1;
    repeat (4) tick();
    req0_valid = 1'b0;
    chk("rmd_lvl", level, 3);
    chk("rmd_en", rr_enable, 1);
    c0 = cmp_cnt;
    resetn = 1'b0;
    tick();
    chk("rmd_en_after", rr_enable, 0);
    chk("rmd_lvl_after", level, 0);
    chk("rmd_busy_after", busy, 0);
    chk("rmd_cmp_after", cmp_valid, 0);
    chk("rmd_cmd_after", rr_cmd, 0);
    resetn = 1'b1;
    repeat (5) tick();
    chk("rmd_no_cmp", cmp_cnt, c0);
    chk("rmd_idle_en", rr_enable, 0);

    // Contention: both valid from reset
    resetn = 1'b0; tick();
    req0_cmd = mk(1, 1, 1, 1); req1_cmd = mk(2, 2, 2, 2);
    req0_valid = 1'b1; req1_valid = 1'b1; resetn = 1'b1;
    #1;
    chk("ct_g0_r0", req0_ready, 1);
    chk("ct_g0_r1", req1_ready, 0);
    tick();
    chk("ct_g1_r1", req1_ready, 1);
    chk("ct_g1_r0", req0_ready, 0);
    tick();
    chk("ct_lvl_e1", level, 1);
    chk("ct_g2_r0", req0_ready, 1);
    tick();
    chk("ct_g3_r1", req1_ready, 1);
    tick();
    chk("ct_g4_r0", req0_ready, 1);
    tick();
    chk("ct_full_lvl", level, 4);
    chk("ct_full_r0", req0_ready, 0);
    chk("ct_full_r1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    src_q.delete();
    rr_done = 1'b1;
    drain();
    rr_done = 1'b0;
    chk("ct_src_cnt", src_q.size(), 5);
    if (src_q.size() == 5) begin
      chk("ct_src0", src_q[0], 0);
      chk("ct_src1", src_q[1], 1);
      chk("ct_src2", src_q[2], 0);
      chk("ct_src3", src_q[3], 1);
      chk("ct_src4", src_q[4], 0);
    end
    chk("ct_lvl_end", level, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
